// File: rtl/btn_pkg.sv
// Shared types and board-clock timing defaults for the push-button front end.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    // 100 MHz board clock: 10 ms debounce, 500 ms first repeat, 100 ms repeat period
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronise, debounce, press/release edge pulses and auto-repeat.
//   state  | meaning
//   IDLE   | button released, waiting for a debounced rise
//   HOLD   | pressed, counting towards the first repeat
//   REPEAT | held past the first repeat, pulsing every REPEAT_PERIOD cycles
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat,
    output logic btn_step
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [DW-1:0] DCNT_TC = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_TC   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_TC   = RW'(REPEAT_PERIOD - 1);

    logic          w_btn_s;
    logic [DW-1:0] r_dcnt;
    logic          r_stable;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_repeat;
    logic          r_step;
    btn_state_t    r_state;
    btn_state_t    w_state_nxt;
    logic [RW-1:0] r_rcnt;
    logic [RW-1:0] w_rcnt_nxt;
    logic          w_repeat_nxt;
    logic          w_rise;
    logic          w_fall;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (w_btn_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dcnt   <= '0;
            r_stable <= 1'b0;
        end else if (w_btn_s == r_stable) begin
            r_dcnt <= '0;
        end else if (r_dcnt == DCNT_TC) begin
            r_stable <= ~r_stable;
            r_dcnt   <= '0;
        end else begin
            r_dcnt <= r_dcnt + DW'(1);
        end
    end

    // r_stable is the debounced level one cycle early, so level and edge pulses land together
    assign w_rise = r_stable & ~r_level;
    assign w_fall = ~r_stable & r_level;

    always_comb begin
        w_state_nxt  = r_state;
        w_rcnt_nxt   = r_rcnt;
        w_repeat_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = HOLD;
                    w_rcnt_nxt  = '0;
                end
            end
            HOLD: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_rcnt_nxt  = '0;
                end else if (r_rcnt == RD_TC) begin
                    if (REPEAT_EN != 0) begin
                        w_repeat_nxt = 1'b1;
                        w_rcnt_nxt   = '0;
                        w_state_nxt  = REPEAT;
                    end
                end else begin
                    w_rcnt_nxt = r_rcnt + RW'(1);
                end
            end
            REPEAT: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_rcnt_nxt  = '0;
                end else if (r_rcnt == RP_TC) begin
                    w_repeat_nxt = 1'b1;
                    w_rcnt_nxt   = '0;
                end else begin
                    w_rcnt_nxt = r_rcnt + RW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_rcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_rcnt    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            r_step    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_level   <= r_stable;
            r_press   <= w_rise;
            r_release <= w_fall;
            r_repeat  <= w_repeat_nxt;
            r_step    <= w_rise | w_repeat_nxt;
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign btn_repeat  = r_repeat;
    assign btn_step    = r_step;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing (DEBOUNCE=4, DELAY=20, PERIOD=5).
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_a = 1'b0;
    logic btn_b = 1'b0;
    logic a_level, a_press, a_release, a_repeat, a_step;
    logic b_level, b_press, b_release, b_repeat, b_step;
    logic w_level, w_press, w_release, w_repeat, w_step;
    logic sel_b = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int q_press[$];
    int q_rel[$];
    int q_rep[$];
    int q_exp[$];
    int n_step, n_level_hi, n_bad_step;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB), .REPEAT_DELAY (RD), .REPEAT_PERIOD (RP), .REPEAT_EN (1)
    ) dut_a (
        .clk (clk), .reset (reset), .btn_in (btn_a),
        .btn_level (a_level), .btn_press (a_press), .btn_release (a_release),
        .btn_repeat (a_repeat), .btn_step (a_step)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB), .REPEAT_DELAY (RD), .REPEAT_PERIOD (RP), .REPEAT_EN (0)
    ) dut_b (
        .clk (clk), .reset (reset), .btn_in (btn_b),
        .btn_level (b_level), .btn_press (b_press), .btn_release (b_release),
        .btn_repeat (b_repeat), .btn_step (b_step)
    );

    assign w_level   = sel_b ? b_level   : a_level;
    assign w_press   = sel_b ? b_press   : a_press;
    assign w_release = sel_b ? b_release : a_release;
    assign w_repeat  = sel_b ? b_repeat  : a_repeat;
    assign w_step    = sel_b ? b_step    : a_step;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_q(input string tag, input int act[$], input int exp[$]);
        check_eq({tag, "_count"}, act.size(), exp.size());
        for (int i = 0; i < act.size() && i < exp.size(); i++)
            check_eq($sformatf("%s[%0d]", tag, i), act[i], exp[i]);
    endtask

    function automatic logic pin_at(input int s, input int bounce, input int hold);
        if (s < bounce) return ((s / 3) % 2) == 0;
        if (hold > 0 && s >= hold) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive(input logic v);
        if (sel_b) btn_b = v;
        else       btn_a = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn_a = 1'b0;
        btn_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Edge e is the e-th rising edge after the pin first takes its scenario value.
    task automatic run_scn(input logic use_b, input int bounce, input int hold,
                           input int n_edges, input int rst_edge);
        sel_b = use_b;
        q_press.delete();
        q_rel.delete();
        q_rep.delete();
        n_step = 0;
        n_level_hi = 0;
        n_bad_step = 0;
        drive(pin_at(0, bounce, hold));
        for (int e = 0; e < n_edges; e++) begin
            @(posedge clk);
            #1;
            if (w_press)   q_press.push_back(e);
            if (w_release) q_rel.push_back(e);
            if (w_repeat)  q_rep.push_back(e);
            if (w_step)    n_step++;
            if (w_level)   n_level_hi++;
            if ((w_step !== (w_press | w_repeat)) || (w_press && w_repeat)) n_bad_step++;
            if (e == rst_edge) begin
                reset = 1'b1;
                #1;
                check_eq("async_reset_outputs",
                         int'({w_level, w_press, w_release, w_repeat, w_step}), 0);
                #1 reset = 1'b0;
            end
            drive(pin_at(e + 1, bounce, hold));
        end
    endtask

    initial begin
        do_reset();
        check_eq("reset_a_outputs", int'({a_level, a_press, a_release, a_repeat, a_step}), 0);
        check_eq("reset_b_outputs", int'({b_level, b_press, b_release, b_repeat, b_step}), 0);
        check_eq("reset_a_state", int'(dut_a.r_state), int'(IDLE));

        // clean press held
        run_scn(1'b0, 0, 0, 45, -1);
        q_exp.delete(); q_exp.push_back(6);
        check_q("clean_press", q_press, q_exp);
        q_exp.delete(); q_exp.push_back(26); q_exp.push_back(31); q_exp.push_back(36); q_exp.push_back(41);
        check_q("clean_repeat", q_rep, q_exp);
        check_eq("clean_release_count", q_rel.size(), 0);
        check_eq("clean_level_hi_cycles", n_level_hi, 39);
        check_eq("clean_step_count", n_step, 5);
        check_eq("clean_step_shape", n_bad_step, 0);

        // 3-high/3-low bounce x5 then stable high
        do_reset();
        run_scn(1'b0, 30, 0, 45, -1);
        q_exp.delete(); q_exp.push_back(36);
        check_q("bounce_press", q_press, q_exp);
        check_eq("bounce_release_count", q_rel.size(), 0);
        check_eq("bounce_repeat_count", q_rep.size(), 0);
        check_eq("bounce_level_hi_cycles", n_level_hi, 9);

        // short press, released before the first repeat
        do_reset();
        run_scn(1'b0, 0, 12, 40, -1);
        q_exp.delete(); q_exp.push_back(6);
        check_q("short_press", q_press, q_exp);
        q_exp.delete(); q_exp.push_back(18);
        check_q("short_release", q_rel, q_exp);
        check_eq("short_repeat_count", q_rep.size(), 0);
        check_eq("short_level_hi_cycles", n_level_hi, 12);
        check_eq("short_state_idle", int'(dut_a.r_state), int'(IDLE));

        // release in REPEAT; fall lands on the edge a third repeat would have used
        do_reset();
        run_scn(1'b0, 0, 30, 50, -1);
        q_exp.delete(); q_exp.push_back(26); q_exp.push_back(31);
        check_q("rptrel_repeat", q_rep, q_exp);
        q_exp.delete(); q_exp.push_back(36);
        check_q("rptrel_release", q_rel, q_exp);
        check_eq("rptrel_press_count", q_press.size(), 1);
        check_eq("rptrel_state_idle", int'(dut_a.r_state), int'(IDLE));
        check_eq("rptrel_step_shape", n_bad_step, 0);

        // reset mid-hold with the pin still high
        do_reset();
        run_scn(1'b0, 0, 0, 50, 28);
        q_exp.delete(); q_exp.push_back(6); q_exp.push_back(35);
        check_q("midrst_press", q_press, q_exp);
        q_exp.delete(); q_exp.push_back(26);
        check_q("midrst_repeat", q_rep, q_exp);
        check_eq("midrst_release_count", q_rel.size(), 0);

        // auto-repeat disabled
        do_reset();
        run_scn(1'b1, 0, 0, 100, -1);
        q_exp.delete(); q_exp.push_back(6);
        check_q("norpt_press", q_press, q_exp);
        check_eq("norpt_repeat_count", q_rep.size(), 0);
        check_eq("norpt_step_count", n_step, 1);
        check_eq("norpt_state_hold", int'(dut_b.r_state), int'(HOLD));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
